rom_stream: RTL and testbench

- Read sequencer that sits directly upstream of a synchronous ROM (1-cycle registered read latency).
- Walks a contiguous address range and presents the words as a valid/ready stream to downstream consumers (font/tile loaders, RAM copy engines, palette loaders).
- Owns the ROM address port and absorbs the ROM latency with a 2-entry buffer, so backpressure never loses or duplicates a word.

---
 rtl/rom_stream_pkg.sv | 16 +
 rtl/rom_stream_skid_buf2.sv | 75 +++++++
 rtl/rom_stream.sv | 135 +++++++++++++
 tb/tb_rom_stream.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_stream_pkg.sv
// Shared constants and helpers for the rom_stream read sequencer.
package rom_stream_pkg;

  // Sequencer states, kept as plain constants so the encoding is fixed.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  // Buffer occupancy once this cycle's push and pop have both taken effect.
  function automatic logic [1:0] occ_after(input logic [1:0] occ,
                                           input logic       push,
                                           input logic       pop);
    return occ + {1'b0, push} - {1'b0, pop};
  endfunction

endpackage

// File: rtl/rom_stream_skid_buf2.sv
// Two-entry synchronous FIFO with a registered head. Slot 0 drives the
// output directly; slot 1 only fills while the head is stalled.
module skid_buf2 #(
  parameter int DATAW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DATAW-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [DATAW-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       count
);

  logic [DATAW-1:0] d0;
  logic [DATAW-1:0] d1;
  logic             v0;
  logic             v1;
  logic             pop;
  logic             push;

  // Slot 1 is only ever occupied while slot 0 is, so a ready consumer
  // always frees one slot in the same cycle.
  assign pop       = v0 && out_ready;
  assign in_ready  = !v1 || out_ready;
  assign push      = in_valid && in_ready;
  assign out_data  = d0;
  assign out_valid = v0;
  assign count     = {1'b0, v0} + {1'b0, v1};

  // Shift/fill the two slots; the head only changes on pop or when empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: both data slots are reset (not just the valid bits) because
      // slot 0 is the visible stream data, which must read zero after reset.
      d0 <= '0;
      d1 <= '0;
      v0 <= 1'b0;
      v1 <= 1'b0;
    end else begin
      case ({push, pop})
        2'b11: begin
          if (v1) begin
            d0 <= d1;
            d1 <= in_data;
          end else begin
            d0 <= in_data;
          end
        end
        2'b10: begin
          if (!v0) begin
            d0 <= in_data;
            v0 <= 1'b1;
          end else begin
            d1 <= in_data;
            v1 <= 1'b1;
          end
        end
        2'b01: begin
          if (v1) begin
            d0 <= d1;
            v1 <= 1'b0;
          end else begin
            v0 <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/rom_stream.sv
// Read sequencer in front of a synchronous ROM: walks base..base+len-1
// (modulo the ROM size) and presents the words as a valid/ready stream.
//
// The ROM re-reads rom_addr every cycle, so while rom_addr holds, its output
// keeps showing the most recently issued word. That lets the last issued
// word wait on the ROM output until the buffer has room, while the word
// issued before it (visible only for the one cycle after rom_addr moves on)
// must be pushed immediately. A new read is issued only when the buffer will
// hold at most one word after this cycle, so that mandatory push always fits.
module rom_stream
  import rom_stream_pkg::*;
#(
  parameter int ADDRW = 8,
  parameter int DATAW = 8,
  parameter int LENW  = ADDRW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ADDRW-1:0] base,
  input  logic [LENW-1:0]  len,
  output logic             busy,
  output logic             done,
  output logic [ADDRW-1:0] rom_addr,
  input  logic [DATAW-1:0] rom_data,
  output logic [DATAW-1:0] strm_data,
  output logic             strm_valid,
  input  logic             strm_ready
);

  logic [1:0]      state;
  logic [LENW-1:0] issue_left;
  logic [LENW-1:0] accept_left;

  // lat_unp : word at rom_addr was issued and is not yet in the buffer.
  // prev_unp: word issued before that is still unbuffered.
  // adv     : rom_addr moved on at the last edge, so rom_data shows the
  //           previous word rather than the one at rom_addr.
  logic lat_unp;
  logic prev_unp;
  logic adv;

  logic       accept_start;
  logic       data_unp;
  logic       fifo_in_ready;
  logic       push;
  logic       pop;
  logic       issue;
  logic       lat_unp_after;
  logic       last_pop;
  logic [1:0] occ;

  assign busy = (state == ST_RUN);
  assign done = (state == ST_FINISH);

  // Issue and buffer-push decisions for this cycle.
  always_comb begin
    // NOTE: every signal gets a value on every path here, so no latch forms.
    accept_start  = (state == ST_IDLE) && start && (len != '0);
    pop           = strm_valid && strm_ready;
    data_unp      = adv ? prev_unp : lat_unp;
    push          = data_unp && fifo_in_ready;
    issue         = (state == ST_RUN) && (issue_left != '0) &&
                    (occ_after(occ, push, pop) < 2'd2);
    lat_unp_after = lat_unp && !(push && !adv);
    last_pop      = pop && (accept_left == LENW'(1));
  end

  // Control FSM and count of words still to be accepted downstream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state       <= ST_IDLE;
      accept_left <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= (len != '0) ? ST_RUN : ST_FINISH;
            accept_left <= len;
          end
        end
        ST_RUN: begin
          if (pop) accept_left <= accept_left - LENW'(1);
          if (last_pop) state <= ST_FINISH;
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // ROM address pointer and tracking of issued-but-unbuffered words.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rom_addr   <= '0;
      issue_left <= '0;
      lat_unp    <= 1'b0;
      prev_unp   <= 1'b0;
      adv        <= 1'b0;
    end else if (accept_start) begin
      rom_addr   <= base;
      issue_left <= len - LENW'(1);
      lat_unp    <= 1'b1;
      prev_unp   <= 1'b0;
      adv        <= 1'b1;
    end else if (issue) begin
      rom_addr   <= rom_addr + ADDRW'(1);
      issue_left <= issue_left - LENW'(1);
      prev_unp   <= lat_unp_after;
      lat_unp    <= 1'b1;
      adv        <= 1'b1;
    end else begin
      lat_unp    <= lat_unp_after;
      prev_unp   <= 1'b0;
      adv        <= 1'b0;
    end
  end

  skid_buf2 #(
    .DATAW (DATAW)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (rom_data),
    .in_valid  (data_unp),
    .in_ready  (fifo_in_ready),
    .out_data  (strm_data),
    .out_valid (strm_valid),
    .out_ready (strm_ready),
    .count     (occ)
  );

endmodule

// File: tb/tb_rom_stream.sv
// Bench for rom_stream: ROM model holds i^0x5A, a scoreboard queue holds the
// expected stream words and a negedge monitor pops and compares them.
module tb_rom_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] base;
  logic [8:0] len;
  logic       busy;
  logic       done;
  logic [7:0] rom_addr;
  logic [7:0] rom_data = 8'h00;
  logic [7:0] strm_data;
  logic       strm_valid;
  logic       strm_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rom_mem[256];

  logic       bp_en  = 1'b0;
  logic [5:0] bp_pat = 6'b101001;  // ready sequence 1,0,0,1,0,1 (bit 0 first)
  int         bp_i   = 0;

  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always #5 clk = ~clk;

  rom_stream dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base       (base),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .strm_data  (strm_data),
    .strm_valid (strm_valid),
    .strm_ready (strm_ready)
  );

  function automatic logic [7:0] rom_model(input logic [7:0] a);
    return a ^ 8'h5A;
  endfunction

  // Synchronous ROM, one-cycle registered read.
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Downstream ready: held high, or a fixed stall pattern.
  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      strm_ready = bp_pat[bp_i];
      bp_i = (bp_i == 5) ? 0 : bp_i + 1;
    end else begin
      strm_ready = 1'b1;
    end
  end

  // Monitor: compares accepted words against the scoreboard and checks that
  // a stalled word stays put.
  always @(negedge clk) begin
    if (prev_stall) begin
      check("hold_valid", strm_valid, 1'b1);
      check("hold_data", strm_data, prev_data);
    end
    if (strm_valid && strm_ready) begin
      if (exp_q.size() == 0) check("unexpected_word", exp_q.size(), 1);
      else check("stream_data", strm_data, exp_q.pop_front());
    end
    prev_stall = strm_valid && !strm_ready;
    prev_data  = strm_data;
  end

  task automatic wait_done(input string name, input int max_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, done, 1'b1);
  endtask

  task automatic push_exp(input logic [7:0] b, input int l);
    logic [7:0] a;
    for (int i = 0; i < l; i++) begin
      a = b + 8'(i);
      exp_q.push_back(rom_model(a));
    end
  endtask

  task automatic run_xfer(input string name, input logic [7:0] b, input logic [8:0] l,
                          input int max_cyc);
    push_exp(b, int'(l));
    base  = b;
    len   = l;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(name, max_cyc);
    tick();
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = rom_model(8'(i));
    rst_n = 1'b0; start = 1'b0; base = 8'h00; len = 9'd0; strm_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valid", strm_valid, 1'b0);
    check("rst_data", strm_data, 8'h00);
    check("rst_addr", rom_addr, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic stream with exact latency, base 0x10 len 4.
    push_exp(8'h10, 4);
    base = 8'h10; len = 9'd4; start = 1'b1;          // cycle N
    @(negedge clk); check("basic_busy_n", busy, 1'b0);
    tick(); start = 1'b0; base = 8'h80; len = 9'd7;  // N+1
    @(negedge clk);
    check("basic_busy_n1", busy, 1'b1);
    check("basic_addr_n1", rom_addr, 8'h10);
    check("basic_valid_n1", strm_valid, 1'b0);
    tick();                                          // N+2
    @(negedge clk); check("basic_valid_n2", strm_valid, 1'b0);
    tick(); @(negedge clk);                          // N+3
    check("basic_valid_n3", strm_valid, 1'b1); check("basic_data_n3", strm_data, 8'h4A);
    tick(); @(negedge clk);                          // N+4
    check("basic_valid_n4", strm_valid, 1'b1); check("basic_data_n4", strm_data, 8'h4B);
    tick(); @(negedge clk);                          // N+5
    check("basic_valid_n5", strm_valid, 1'b1); check("basic_data_n5", strm_data, 8'h48);
    tick(); @(negedge clk);                          // N+6
    check("basic_valid_n6", strm_valid, 1'b1); check("basic_data_n6", strm_data, 8'h49);
    check("basic_busy_n6", busy, 1'b1); check("basic_done_n6", done, 1'b0);
    tick(); @(negedge clk);                          // N+7
    check("basic_done_n7", done, 1'b1); check("basic_busy_n7", busy, 1'b0);
    check("basic_valid_n7", strm_valid, 1'b0);
    tick(); @(negedge clk);                          // N+8
    check("basic_done_n8", done, 1'b0);
    check("basic_drained", exp_q.size(), 0);
    tick();

    // Backpressure with ready pattern 1,0,0,1,0,1...
    bp_i = 0; bp_en = 1'b1;
    run_xfer("bp", 8'h10, 9'd4, 60);
    bp_en = 1'b0;
    tick();

    // Address wrap: rom_addr FE, FF, 00, 01, then holds.
    push_exp(8'hFE, 4);
    base = 8'hFE; len = 9'd4; start = 1'b1;
    tick(); start = 1'b0;
    @(negedge clk); check("wrap_addr_n1", rom_addr, 8'hFE);
    tick(); @(negedge clk); check("wrap_addr_n2", rom_addr, 8'hFF);
    tick(); @(negedge clk); check("wrap_addr_n3", rom_addr, 8'h00);
    tick(); @(negedge clk); check("wrap_addr_n4", rom_addr, 8'h01);
    tick(); @(negedge clk); check("wrap_addr_n5", rom_addr, 8'h01);
    wait_done("wrap", 20);
    tick();
    check("wrap_drained", exp_q.size(), 0);

    // Zero length: done at N+1, no busy, no word, no ROM issue.
    base = 8'h77; len = 9'd0; start = 1'b1;
    tick(); start = 1'b0;
    @(negedge clk);
    check("zero_done_n1", done, 1'b1); check("zero_busy_n1", busy, 1'b0);
    check("zero_valid_n1", strm_valid, 1'b0); check("zero_addr_n1", rom_addr, 8'h01);
    tick(); @(negedge clk);
    check("zero_done_n2", done, 1'b0); check("zero_busy_n2", busy, 1'b0);
    check("zero_valid_n2", strm_valid, 1'b0);
    tick();

    // Full ROM.
    run_xfer("full", 8'h00, 9'd256, 400);

    // Start while busy is ignored; start in FINISH ignored, next cycle accepted.
    push_exp(8'h20, 8);
    base = 8'h20; len = 9'd8; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    base = 8'h80; len = 9'd5; start = 1'b1;
    tick(); start = 1'b0;
    wait_done("busy_start", 40);
    base = 8'h40; len = 9'd2; start = 1'b1;          // driven in FINISH cycle
    push_exp(8'h40, 2);
    tick(); @(negedge clk);
    check("fin_start_busy", busy, 1'b0); check("fin_start_done", done, 1'b0);
    tick(); start = 1'b0;
    @(negedge clk); check("idle_start_busy", busy, 1'b1);
    wait_done("idle_start", 20);
    tick();
    check("busy_start_drained", exp_q.size(), 0);

    // Reset after 2 of 8 words accepted.
    push_exp(8'h30, 2);
    base = 8'h30; len = 9'd8; start = 1'b1;
    tick(); start = 1'b0;                            // N+1
    tick(); tick(); tick();                          // N+4
    rst_n = 1'b0;
    tick(); rst_n = 1'b1;                            // N+5
    @(negedge clk);
    check("mid_rst_valid", strm_valid, 1'b0); check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0); check("mid_rst_addr", rom_addr, 8'h00);
    check("mid_rst_words", exp_q.size(), 0);
    tick(); @(negedge clk);
    check("mid_rst_done2", done, 1'b0); check("mid_rst_valid2", strm_valid, 1'b0);
    tick();
    run_xfer("post_rst", 8'h05, 9'd3, 20);

    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
